// File: rtl/uart_rx_block.sv
// uart_rx_block: oversampled UART receiver that packs good bytes MSB-first into a wide word.
// Define UART_RX_PARITY_EN to compile in a parity bit after the data bits.
module uart_rx_block #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int WORD_BYTES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx,
    input  logic                    s_tick,
    input  logic                    parity_odd,
    input  logic                    clear,
    output logic                    byte_valid,
    output logic [DATA_BITS-1:0]    byte_data,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic [8*WORD_BYTES-1:0] word_data,
    output logic                    frame_err,
    output logic                    parity_err,
    output logic                    overrun
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam int KW = $clog2(WORD_BYTES + 1);
    localparam int IW = $clog2(8 * WORD_BYTES);
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] S_LAST = BW'(STOP_BITS - 1);
    localparam logic [KW-1:0] K_LAST = KW'(WORD_BYTES - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam state_t AFTER_DATA = PARITY;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
    localparam state_t AFTER_DATA = STOP;
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    state_t                  state_q, state_d;
    logic                    sync_q, rxs_q;
    logic [TW-1:0]           tick_q, tick_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0]    shift_q, shift_d;
    logic                    stop_bad_q, stop_bad_d, par_bad_q, par_bad_d;
    logic [KW-1:0]           k_q, k_d;
    logic                    byte_valid_q, byte_valid_d, word_valid_q, word_valid_d;
    logic                    frame_err_q, frame_err_d, parity_err_q, parity_err_d;
    logic                    overrun_q, overrun_d;
    logic [DATA_BITS-1:0]    byte_data_q, byte_data_d;
    logic [8*WORD_BYTES-1:0] word_data_q, word_data_d;
    logic                    smp, good;
    logic [IW-1:0]           pos;

    always_comb begin
        state_d      = state_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        stop_bad_d   = stop_bad_q;
        par_bad_d    = par_bad_q;
        byte_data_d  = byte_data_q;
        word_data_d  = word_data_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        overrun_d    = 1'b0;
        good         = 1'b0;
        pos          = '0;
        k_d          = clear ? '0 : k_q;
        word_valid_d = word_valid_q & ~word_ready;
        smp    = s_tick && state_q != IDLE && tick_q == (state_q == START ? T_MID : T_END);
        tick_d = (state_q == IDLE || smp) ? '0 : tick_q + TW'(s_tick);
        if (state_q == IDLE && !rxs_q)
            state_d = START;
        if (smp)
            case (state_q)
                START: begin
                    bit_d      = '0;
                    stop_bad_d = 1'b0;
                    par_bad_d  = 1'b0;
                    state_d    = rxs_q ? IDLE : DATA;
                end
                DATA: begin
                    shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q == B_LAST ? '0 : bit_q + 1'b1;
                    state_d = bit_q == B_LAST ? AFTER_DATA : DATA;
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    par_bad_d = rxs_q ^ (^shift_q) ^ parity_odd;
                    state_d   = STOP;
                end
`endif
                STOP: begin
                    stop_bad_d = stop_bad_q | ~rxs_q;
                    bit_d      = bit_q + 1'b1;
                    if (bit_q == S_LAST) begin
                        state_d      = IDLE;
                        frame_err_d  = stop_bad_d;
                        parity_err_d = ~stop_bad_d & par_bad_q;
                        good         = ~stop_bad_d & ~par_bad_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        if (good) begin
            byte_valid_d = 1'b1;
            byte_data_d  = shift_q;
            // a word handed over this cycle frees the buffer for this byte
            if (word_valid_d)
                overrun_d = 1'b1;
            else begin
                pos                  = IW'(8 * (WORD_BYTES - int'(k_d)) - 1);
                word_data_d[pos -: 8] = 8'(shift_q);
                word_valid_d         = k_d == K_LAST;
                k_d                  = word_valid_d ? '0 : k_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q      <= IDLE;
            sync_q       <= 1'b1;
            rxs_q        <= 1'b1;
            tick_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            stop_bad_q   <= 1'b0;
            par_bad_q    <= 1'b0;
            k_q          <= '0;
            byte_valid_q <= 1'b0;
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            byte_data_q  <= '0;
            word_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            sync_q       <= rx;
            rxs_q        <= sync_q;
            tick_q       <= tick_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            stop_bad_q   <= stop_bad_d;
            par_bad_q    <= par_bad_d;
            k_q          <= k_d;
            byte_valid_q <= byte_valid_d;
            word_valid_q <= word_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
            byte_data_q  <= byte_data_d;
            word_data_q  <= word_data_d;
        end

    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;
    assign word_valid = word_valid_q;
    assign word_data  = word_data_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
endmodule
